// File: rtl/dat_fifo_pkg.sv
// dat_fifo_pkg
// Shared definitions for the DAT-line write FIFO and its neighbours.
//   DAT_WORD_WIDTH       word width shared with dat_phys dataFROMFIFO
//   DAT_FIFO_ADDR_WIDTH  default log2 of FIFO depth
//   DAT_FIFO_AF_THRESH   default almost_full level (used with DAT_FIFO_ALMOST_EN)
//   DAT_FIFO_AE_THRESH   default almost_empty level (used with DAT_FIFO_ALMOST_EN)
package dat_fifo_pkg;

  localparam int DAT_WORD_WIDTH      = 32;
  localparam int DAT_FIFO_ADDR_WIDTH = 4;
  localparam int DAT_FIFO_AF_THRESH  = 12;
  localparam int DAT_FIFO_AE_THRESH  = 2;

endpackage

// File: rtl/dat_fifo_ram.sv
// dat_fifo_ram
// Simple dual-port storage array for dat_fifo: one write port and one
// registered read port, both clocked by sd_clock.
// Ports:
//   sd_clock   clock
//   reset      synchronous active-high; clears only the read register
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; rd_data_o loads on the edge it is sampled
//   rd_addr_i  read address
//   rd_data_o  registered read data, holds when rd_en_i is low
module dat_fifo_ram
  import dat_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DAT_WORD_WIDTH,
  parameter int ADDR_WIDTH = DAT_FIFO_ADDR_WIDTH
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage has no reset so it can map onto plain RAM cells.
  always_ff @(posedge sd_clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A read and write to the same address on one edge returns the old word,
  // which is what the FIFO relies on when it is full and reads+writes at once.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dat_fifo.sv
// dat_fifo
// Single-clock word FIFO sitting directly upstream of dat_phys. The host/DMA
// side pushes words for SD write transfers; dat_phys pops them, and data_out
// feeds dat_phys dataFROMFIFO. Fill level and sticky error flags are reported
// to the controller.
// Optional feature macro: DAT_FIFO_ALMOST_EN adds almost_full/almost_empty.
// Ports:
//   sd_clock    clock
//   reset       synchronous active-high reset (also clears data_out)
//   flush       synchronous clear of pointers, count and flags
//   write_en    push request, qualified by !full (or a concurrent pop)
//   data_in     word to push
//   read_en     pop request, qualified by !empty
//   data_out    registered popped word
//   data_valid  one-cycle pulse when data_out was updated
//   full        count == depth
//   empty       count == 0
//   count       words stored, 0..depth
//   overflow    sticky: write attempted while full
//   underflow   sticky: read attempted while empty
//   almost_full / almost_empty  (DAT_FIFO_ALMOST_EN only)
module dat_fifo
  import dat_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DAT_WORD_WIDTH,
  parameter int ADDR_WIDTH = DAT_FIFO_ADDR_WIDTH
`ifdef DAT_FIFO_ALMOST_EN
  ,
  parameter int AF_THRESH  = DAT_FIFO_AF_THRESH,
  parameter int AE_THRESH  = DAT_FIFO_AE_THRESH
`endif
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef DAT_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  data_valid_q;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  clear;

  assign clear = reset | flush;

  // A write into a full FIFO is still accepted when a pop frees a slot on
  // the same edge.
  assign rd_ok = read_en & ~empty_q;
  assign wr_ok = write_en & (~full_q | rd_ok);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Memory accesses are suppressed during reset/flush so a flush leaves
  // data_out untouched.
  dat_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .wr_en_i   (wr_ok & ~clear),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_ok & ~clear),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  // Count never exceeds the depth, so its MSB alone marks full.
  always_ff @(posedge sd_clock) begin
    if (clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q      <= count_d;
      full_q       <= count_d[ADDR_WIDTH];
      empty_q      <= (count_d == '0);
      overflow_q   <= overflow_q | (write_en & ~wr_ok);
      underflow_q  <= underflow_q | (read_en & ~rd_ok);
      data_valid_q <= rd_ok;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign data_valid = data_valid_q;

`ifdef DAT_FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AfLevel = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AeLevel = (ADDR_WIDTH+1)'(AE_THRESH);

  logic almost_full_q;
  logic almost_empty_q;

  // Derived from the next-state count so they move on the same edge as count.
  always_ff @(posedge sd_clock) begin
    if (clear) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= AfLevel);
      almost_empty_q <= (count_d <= AeLevel);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_dat_fifo.sv
// tb_dat_fifo
// Self-checking bench for dat_fifo: a table of directed vectors with
// hand-computed expectations, followed by short hand-written sequences
// for read latency and (with DAT_FIFO_ALMOST_EN) the almost flags.
module tb_dat_fifo;

  logic        sd_clock = 1'b0;
  logic        reset    = 1'b1;
  logic        flush    = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] data_in  = '0;
  logic        read_en  = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
`ifdef DAT_FIFO_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  int checks   = 0;
  int failures = 0;

  dat_fifo dut (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .flush      (flush),
    .write_en   (write_en),
    .data_in    (data_in),
    .read_en    (read_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef DAT_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 sd_clock = ~sd_clock;

  // Stop a runaway simulation rather than hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [31:0] din;
    logic        re;
    logic        fl;
    logic        rst;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic [31:0] dout;
    logic        valid;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic we, input logic [31:0] din, input logic re,
                        input logic fl, input logic rst, input int cnt,
                        input logic f, input logic e, input logic [31:0] dout,
                        input logic valid, input logic ovf, input logic udf);
    vec_t v;
    v.we = we; v.din = din; v.re = re; v.fl = fl; v.rst = rst;
    v.cnt = 5'(cnt); v.full = f; v.empty = e; v.dout = dout;
    v.valid = valid; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=0x%08h required=0x%08h",
               name, idx, act, exp);
    end
  endtask

  // Drive inputs away from the rising edge, then sample just after it.
  task automatic drive(input logic we, input logic [31:0] din, input logic re,
                       input logic fl, input logic rst);
    @(negedge sd_clock);
    write_en = we;
    data_in  = din;
    read_en  = re;
    flush    = fl;
    reset    = rst;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.we, v.din, v.re, v.fl, v.rst);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check("count",      idx, 32'(count),      32'(v.cnt));
    check("full",       idx, 32'(full),       32'(v.full));
    check("empty",      idx, 32'(empty),      32'(v.empty));
    check("data_out",   idx, data_out,        v.dout);
    check("data_valid", idx, 32'(data_valid), 32'(v.valid));
    check("overflow",   idx, 32'(overflow),   32'(v.ovf));
    check("underflow",  idx, 32'(underflow),  32'(v.udf));
  endtask

  initial begin
    logic [31:0] val;

    // Reset, then idle.
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0);
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      addVec(0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);

    // Fill with 1..16.
    for (int k = 1; k <= 16; k++)
      addVec(1, 32'(k), 0, 0, 0, k, (k == 16), 0, 32'h0, 0, 0, 0);

    // Full: read+write pops word 1, stores CAFE0000, no overflow.
    addVec(1, 32'hCAFE0000, 1, 0, 0, 16, 1, 0, 32'h1, 1, 0, 0);
    // Idle: data_out holds, valid drops.
    addVec(0, 32'h0, 0, 0, 0, 16, 1, 0, 32'h1, 0, 0, 0);
    // Full: rejected write sets overflow.
    addVec(1, 32'hDEADBEEF, 0, 0, 0, 16, 1, 0, 32'h1, 0, 1, 0);

    // Drain: 2..16 then CAFE0000.
    for (int i = 1; i <= 16; i++) begin
      val = (i == 16) ? 32'hCAFE0000 : 32'(i + 1);
      addVec(0, 32'h0, 1, 0, 0, 16 - i, 0, (i == 16), val, 1, 1, 0);
    end

    // Empty: read+write -> write accepted, read rejected.
    addVec(1, 32'h12345678, 1, 0, 0, 1, 0, 0, 32'hCAFE0000, 0, 1, 1);
    addVec(0, 32'h0, 1, 0, 0, 0, 0, 1, 32'h12345678, 1, 1, 1);

    // Flush clears flags but keeps data_out.
    addVec(0, 32'h0, 0, 1, 0, 0, 0, 1, 32'h12345678, 0, 0, 0);

    // Wrap: two rounds of push 10 / pop 10.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++)
        addVec(1, 32'hA0000000 + 32'(r * 16 + i), 0, 0, 0, i + 1, 0, 0,
               (r == 0) ? 32'h12345678 : 32'hA0000009, 0, 0, 0);
      for (int i = 0; i < 10; i++)
        addVec(0, 32'h0, 1, 0, 0, 9 - i, 0, (i == 9),
               32'hA0000000 + 32'(r * 16 + i), 1, 0, 0);
    end

    // Underflow on a lone read, then fill to 7 and flush mid-fill.
    addVec(0, 32'h0, 1, 0, 0, 0, 0, 1, 32'hA0000019, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      addVec(1, 32'hB0 + 32'(i), 0, 0, 0, i + 1, 0, 0, 32'hA0000019, 0, 0, 1);
    addVec(1, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 1, 32'hA0000019, 0, 0, 0);
    addVec(0, 32'h0, 0, 0, 0, 0, 0, 1, 32'hA0000019, 0, 0, 0);

    // Reset clears data_out, unlike flush.
    addVec(0, 32'h0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Read latency: valid pulses for exactly one cycle after the read edge.
    drive(1, 32'h55AA55AA, 0, 0, 0);
    check("lat_count",  1000, 32'(count), 32'd1);
    drive(0, 32'h0, 1, 0, 0);
    check("lat_valid",  1001, 32'(data_valid), 32'd1);
    check("lat_data",   1001, data_out, 32'h55AA55AA);
    drive(0, 32'h0, 0, 0, 0);
    check("lat_pulse",  1002, 32'(data_valid), 32'd0);
    check("lat_hold",   1002, data_out, 32'h55AA55AA);
    check("lat_empty",  1002, 32'(empty), 32'd1);

`ifdef DAT_FIFO_ALMOST_EN
    drive(0, 32'h0, 0, 1, 0);
    check("af_flush", 2000, 32'(almost_full),  32'd0);
    check("ae_flush", 2000, 32'(almost_empty), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      drive(1, 32'hC0 + 32'(k), 0, 0, 0);
      check("af_fill", 2000 + k, 32'(almost_full),  32'(k >= 12));
      check("ae_fill", 2000 + k, 32'(almost_empty), 32'(k <= 2));
    end
    for (int k = 11; k >= 2; k--) begin
      drive(0, 32'h0, 1, 0, 0);
      check("af_drain", 2100 + k, 32'(almost_full),  32'd0);
      check("ae_drain", 2100 + k, 32'(almost_empty), 32'(k <= 2));
    end
`endif

    drive(0, 32'h0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dat_fifo.md
Name: dat_fifo

Overview:
- Synchronous single-clock 32-bit word FIFO directly upstream of dat_phys.
- Host/DMA side pushes words for SD write transfers.
- dat_phys pops words, and data_out drives dat_phys dataFROMFIFO.
- Decouples host word rate from DAT-line serialisation.
- Reports fill level and sticky error flags for the controller.

Parameters:
DATA_WIDTH, 32, word width; must match dat_phys dataFROMFIFO.
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH = 16 words.
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (optional feature only).
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (optional feature only).

Ports:
sd_clock  in  1  sole clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents and flags; same effect as reset on FIFO state.
write_en  in  1  push request, qualified internally by !full.
data_in  in  DATA_WIDTH  word to push.
read_en  in  1  pop request from dat_phys, qualified internally by !empty.
data_out  out  DATA_WIDTH  registered popped word, to dataFROMFIFO.
data_valid  out  1  one-cycle pulse: data_out updated this cycle.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset or flush (reset has priority; both override read/write that cycle):
  - wr_ptr, rd_ptr, count = 0; empty=1; full=0.
  - overflow=0; underflow=0; data_valid=0.
  - data_out = 0 on reset; unchanged on flush. Memory contents not cleared.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count is updated by an explicit counter, not pointer difference.
- Write accepted (wr_ok) = write_en && (!full || rd_ok).
  - Stores data_in at wr_ptr; wr_ptr++.
- Read accepted (rd_ok) = read_en && !empty.
  - data_out <= mem[rd_ptr] on the next edge; rd_ptr++; data_valid=1 for that one cycle.
  - Latency: read_en sampled at edge N, data_out/data_valid valid after edge N.
  - No fall-through.
- Simultaneous events:
  - Full, read+write: both accepted; count unchanged; full stays 1; no overflow.
  - Empty, read+write: write accepted; read rejected; underflow set; count becomes 1.
  - Otherwise read+write: count unchanged.
- count: +1 on wr_ok only; -1 on rd_ok only. Never exceeds DEPTH, never below 0.
- Error flags:
  - overflow set when write_en && !wr_ok.
  - underflow set when read_en && !rd_ok.
  - Both hold until reset/flush. Rejected accesses do not move pointers.
- data_out holds its last value when no read is accepted.
- full/empty/count are registered and reflect the state after the last edge.

Optional Feature:
- DAT_FIFO_ALMOST_EN defined:
  - Adds registered outputs almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH).
  - Both are computed from the next-state count, so they update in the same cycle as count.
  - Reset/flush values: almost_full=0, almost_empty=1.
- Undefined: ports and logic absent; AF_THRESH/AE_THRESH unused.

Decomposition:
- Shared definitions include holds:
  - DAT_WORD_WIDTH (32), shared with dat_phys dataFROMFIFO.
  - Default DAT_FIFO_ADDR_WIDTH.
  - Default threshold constants.
- Sub-module dat_fifo_ram: simple dual-port array with one write port and one registered read port, both on sd_clock.
- Pointer, count, flag and control logic stays in dat_fifo.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, data_out=0, flags=0.
- Push 0x00000001..0x00000010 (16 words) -> full=1 after 16th edge, count=16; then pop 16 -> data_out sequence 1..16, each with data_valid pulse one cycle after read_en; empty=1 at end.
- At full, assert write_en with 0xDEADBEEF -> overflow=1, count=16, contents unchanged; at full, read+write 0xCAFE0000 -> count stays 16, word later pops in 17th-logical position, no overflow.
- At empty, read+write 0x12345678 -> underflow=1, count=1, data_valid=0; next read -> data_out=0x12345678.
- Wrap: push 10, pop 10, push 10, pop 10 -> correct order, pointers wrapped, count returns 0; flush mid-fill with count=7 -> count=0, empty=1, flags cleared, data_out unchanged.
- With DAT_FIFO_ALMOST_EN: fill to 12 -> almost_full=1 on 12th write edge; drain to 2 -> almost_empty=1.
